sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_pkg.sv | 26 ++
 rtl/sram_controller_if.sv | 23 ++
 rtl/sram_controller.sv | 102 ++++++++++
 tb/tb_sram_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller.
// State encoding, default window/timing and SRAM address width.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0040_0000;
    localparam logic [31:0] DEF_SIZE        = 32'h0040_0000;
    localparam int          DEF_WAIT_CYCLES = 2;
    localparam int          SRAM_AW         = 20;

    // Unsigned window test; wraps correctly below the base.
    function automatic logic addr_hit(
        input logic [31:0] a,
        input logic [31:0] base,
        input logic [31:0] size
    );
        return (a - base) < size;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Bus-side request/response bundle of the SRAM controller.
// The master drives requests, the slave answers.
interface sram_controller_if;

    logic        rreq;
    logic        wreq;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        ack;

    modport master (
        output rreq, wreq, addr, wdata,
        input  rdata, busy, ack
    );

    modport slave (
        input  rreq, wreq, addr, wdata,
        output rdata, busy, ack
    );

endinterface

// File: rtl/sram_controller.sv
// Single-FSM asynchronous SRAM controller.
// One full-word access at a time: setup, strobe, hold.
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0] SIZE        = DEF_SIZE,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_dout,
    input  logic [31:0]        sram_din,
    output logic               sram_doe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [3:0]         sram_be_n
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            op_wr;
    logic [31:0]     rdata_q;
    logic [31:0]     off;
    logic            accept;

    assign off       = bus.addr - BASE_ADDR;
    assign bus.ack   = (bus.rreq | bus.wreq) & addr_hit(bus.addr, BASE_ADDR, SIZE);
    assign accept    = (state == IDLE) & bus.ack;
    assign bus.rdata = rdata_q;
    assign sram_be_n = 4'b0000;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and strobes decoded from state and latched op.
    always_comb begin
        state_nx  = state;
        bus.busy  = 1'b0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_doe  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = SETUP;
            end
            SETUP: begin
                bus.busy  = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe_n = op_wr;
                sram_doe  = op_wr;
                state_nx  = STROBE;
            end
            STROBE: begin
                bus.busy  = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe_n = op_wr;
                sram_we_n = ~op_wr;
                sram_doe  = op_wr;
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                sram_doe = op_wr;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Access latch, strobe counter and read capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_addr <= '0;
            sram_dout <= '0;
            op_wr     <= 1'b0;
            cnt       <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                sram_addr <= off[21:2];
                sram_dout <= bus.wdata;
                op_wr     <= bus.wreq;
            end
            if (state == SETUP) cnt <= CW'(WAIT_CYCLES - 1);
            if (state == STROBE) begin
                if (cnt != '0)  cnt <= cnt - CW'(1);
                else if (!op_wr) rdata_q <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller.
// Directed vectors, corner sequences and random traffic vs a memory model.
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          W    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_controller_if bus ();
    sram_controller_if bus1 ();

    logic [19:0] sram_addr;
    logic [31:0] sram_dout;
    logic [31:0] sram_din;
    logic        sram_doe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    logic [19:0] s1_addr;
    logic [31:0] s1_dout;
    logic [31:0] s1_din;
    logic        s1_doe, s1_ce_n, s1_oe_n, s1_we_n;
    logic [3:0]  s1_be_n;

    sram_controller #(.BASE_ADDR(BASE), .SIZE(32'h0040_0000), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset), .bus(bus),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_doe(sram_doe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_controller #(.BASE_ADDR(BASE), .SIZE(32'h0040_0000), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .sram_addr(s1_addr), .sram_dout(s1_dout), .sram_din(s1_din),
        .sram_doe(s1_doe), .sram_ce_n(s1_ce_n), .sram_oe_n(s1_oe_n),
        .sram_we_n(s1_we_n), .sram_be_n(s1_be_n)
    );

    assign s1_din = 32'hCAFE_F00D;

    // Power-on content of the SRAM device.
    function automatic logic [31:0] pattern(input int w);
        if (w == 0) return 32'hDEAD_BEEF;
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // SRAM device model: write on clock while CE/WE low, async read on OE low.
    bit [31:0] mem   [0:1023];
    bit        wrote [0:1023];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_doe) begin
            mem[sram_addr[9:0]]   <= sram_dout;
            wrote[sram_addr[9:0]] <= 1'b1;
        end
    end
    assign sram_din = sram_oe_n ? 32'h0 :
                      (wrote[sram_addr[9:0]] ? mem[sram_addr[9:0]] : pattern(int'(sram_addr[9:0])));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word-addressed memory built from transactions.
    logic [31:0] exp_mem [int];
    logic [31:0] last_rd;

    function automatic logic [31:0] model_read(input int w);
        return exp_mem.exists(w) ? exp_mem[w] : pattern(w);
    endfunction

    // One access; call just after a rising edge with the DUT idle.
    task automatic access(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit inject,
                          output logic [31:0] got);
        int busy_c, we_c, ce_c;
        bit stab;
        logic [19:0] ew;
        ew = 20'((a - BASE) >> 2);
        bus.rreq = r; bus.wreq = w; bus.addr = a; bus.wdata = d;
        #1 chk("ack_on_accept", {31'b0, bus.ack}, 32'd1);
        @(posedge clk); #1;
        bus.rreq = 0; bus.wreq = 0;
        bus.addr = $urandom; bus.wdata = $urandom;
        busy_c = 0; we_c = 0; ce_c = 0; stab = 1;
        for (int i = 1; i <= W + 2; i++) begin
            @(negedge clk);
            if (bus.busy) busy_c++;
            if (!sram_we_n) we_c++;
            if (!sram_ce_n) ce_c++;
            if (sram_addr !== ew) stab = 0;
            if (w && (sram_dout !== d || sram_doe !== 1'b1)) stab = 0;
            if (inject && i == 2) begin
                bus.rreq = 1; bus.addr = BASE + 32'h100;
                #1 chk("ack_while_busy", {31'b0, bus.ack}, 32'd1);
            end
            if (inject && i == 3) bus.rreq = 0;
            if (i == W + 2) begin
                chk("done_busy", {31'b0, bus.busy}, 32'd0);
                chk("done_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
                chk("done_doe", {31'b0, sram_doe}, {31'b0, w});
                got = bus.rdata;
            end
        end
        chk("busy_cycles", busy_c, W + 1);
        chk("we_low_cycles", we_c, w ? W : 0);
        chk("ce_low_cycles", ce_c, W + 1);
        chk("addr_data_stable", {31'b0, stab}, 32'd1);
        @(posedge clk); #1;
        if (inject) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("no_extra_access", {31'b0, bus.busy}, 32'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    // Transaction plus model bookkeeping and checks.
    task automatic txn(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit inject);
        logic [31:0] got;
        int wd;
        wd = int'((a - BASE) >> 2);
        access(r, w, a, d, inject, got);
        if (w) begin
            exp_mem[wd] = d;
            chk("rdata_kept_on_write", got, last_rd);
        end else begin
            chk("read_data", got, model_read(wd));
            last_rd = model_read(wd);
        end
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        bit          ack;
    } vec_t;

    vec_t vt [10];

    initial begin
        vt[0] = '{1, 0, 32'h0040_0000, 1};
        vt[1] = '{0, 1, 32'h0040_0000, 1};
        vt[2] = '{0, 0, 32'h0040_0000, 0};
        vt[3] = '{1, 0, 32'h0080_0000, 0};
        vt[4] = '{1, 0, 32'h003F_FFFC, 0};
        vt[5] = '{1, 0, 32'h007F_FFFC, 1};
        vt[6] = '{0, 1, 32'h0080_0004, 0};
        vt[7] = '{1, 1, 32'h0060_0000, 1};
        vt[8] = '{1, 0, 32'h0000_0000, 0};
        vt[9] = '{1, 0, 32'hFFFF_FFFC, 0};

        reset = 1;
        bus.rreq = 0; bus.wreq = 0; bus.addr = 0; bus.wdata = 0;
        bus1.rreq = 0; bus1.wreq = 0; bus1.addr = 0; bus1.wdata = 0;
        last_rd = 0;

        @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_strobes", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_doe}, 32'hE);
        chk("rst_addr", {12'b0, sram_addr}, 32'd0);
        chk("rst_dout", sram_dout, 32'd0);
        chk("be_n", {28'b0, sram_be_n}, 32'd0);
        #2 reset = 0;

        // First request right after reset release; word 0 holds DEADBEEF.
        txn(1, 0, 32'h0040_0000, 32'h0, 0);
        chk("read_deadbeef", last_rd, 32'hDEAD_BEEF);

        // Combinational ack in IDLE, request removed before the edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.rreq = vt[i].r; bus.wreq = vt[i].w; bus.addr = vt[i].a;
            #1;
            chk($sformatf("vec%0d_ack", i), {31'b0, bus.ack}, {31'b0, vt[i].ack});
            chk($sformatf("vec%0d_idle", i), {30'b0, bus.busy, sram_ce_n}, 32'd1);
            bus.rreq = 0; bus.wreq = 0;
        end
        @(posedge clk); #1;

        // Misses held across edges never start an access.
        bus.rreq = 1; bus.addr = 32'h0080_0000;
        @(negedge clk);
        chk("miss_hi_ack", {31'b0, bus.ack}, 32'd0);
        @(negedge clk);
        chk("miss_hi_busy", {30'b0, bus.busy, sram_ce_n}, 32'd1);
        bus.addr = 32'h003F_FFFC;
        @(negedge clk);
        chk("miss_lo_ack", {31'b0, bus.ack}, 32'd0);
        chk("miss_lo_idle", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        bus.rreq = 0;
        @(posedge clk); #1;

        // Write then read back.
        txn(0, 1, 32'h0040_0010, 32'h1234_5678, 0);
        chk("wr_word", {31'b0, wrote[4]}, 32'd1);
        txn(1, 0, 32'h0040_0010, 32'h0, 0);
        chk("readback", last_rd, 32'h1234_5678);

        // Collision: write wins; read during STROBE is dropped.
        txn(1, 1, 32'h0040_0020, 32'hA5A5_0F0F, 1);
        txn(1, 0, 32'h0040_0020, 32'h0, 0);
        chk("collision_rb", last_rd, 32'hA5A5_0F0F);

        // Reset during the strobe of a write.
        bus.wreq = 1; bus.addr = 32'h0040_0040; bus.wdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus.wreq = 0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_we", {31'b0, sram_we_n}, 32'd0);
        reset = 1;
        #1;
        chk("rst_mid_strobes", {29'b0, sram_we_n, sram_ce_n, sram_doe}, 32'd6);
        chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mid_rdata", bus.rdata, 32'd0);
        #1 reset = 0;
        last_rd = 0;
        chk("rst_no_write", {31'b0, wrote[16]}, 32'd0);
        txn(1, 0, 32'h0040_0000, 32'h0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            bit w, r;
            int wd;
            w  = 1'($urandom_range(0, 1));
            r  = !w || ($urandom_range(0, 3) == 0);
            wd = $urandom_range(0, 1023);
            txn(r, w, BASE + 32'(wd * 4) + 32'($urandom_range(0, 3)), $urandom, 0);
        end

        // Single-cycle strobe build: accept to valid in three cycles.
        begin
            int lat;
            bus1.rreq = 1; bus1.addr = BASE + 32'h8;
            @(posedge clk); #1;
            bus1.rreq = 0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while ((bus1.busy || bus1.rdata !== 32'hCAFE_F00D) && lat < 10);
            chk("w1_latency", lat, 3);
            chk("w1_rdata", bus1.rdata, 32'hCAFE_F00D);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
